// File: rtl/div_pkg.sv
// Shared widths, handshake encodings and FSM state type for the divider.
package div_pkg;
  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_if;
  import div_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per cycle,
// returns {remainder, quotient}, handles divide-by-zero and annul.
module div
  import div_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  div_state_e        state;
  logic [64:0]       dividend;
  logic [RegBus-1:0] divisor;
  logic [5:0]        cnt;
  logic              signed_div;
  logic              sign1;
  logic              sign2;

  logic [RegBus:0]   trial;
  logic [RegBus-1:0] op1_abs;
  logic [RegBus-1:0] op2_abs;
  logic [RegBus-1:0] q_fix;
  logic [RegBus-1:0] r_fix;

  // Trial subtraction of the divisor from the current partial remainder.
  assign trial = {1'b0, dividend[63:32]} - {1'b0, divisor};

  // Operand magnitudes; only negative operands in signed mode are negated.
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // Sign restoration: quotient negative when signs differ, remainder follows the dividend.
  assign q_fix = (signed_div && (sign1 ^ sign2)) ? (~dividend[31:0] + 32'd1) : dividend[31:0];
  assign r_fix = (signed_div && sign1) ? (~dividend[64:33] + 32'd1) : dividend[64:33];

  // FSM and datapath; the final {r, q} is parked in dividend so DivEnd can re-publish it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= DivFree;
      dividend     <= '0;
      divisor      <= ZeroWord;
      cnt          <= '0;
      signed_div   <= 1'b0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            state      <= (bus.opdata2_i == ZeroWord) ? DivByZero : DivOn;
            cnt        <= '0;
            signed_div <= bus.signed_div_i;
            sign1      <= bus.signed_div_i & bus.opdata1_i[31];
            sign2      <= bus.signed_div_i & bus.opdata2_i[31];
            divisor    <= op2_abs;
            dividend   <= {32'b0, op1_abs, 1'b0};
          end
        end
        DivByZero: begin
          dividend <= '0;
          state    <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt < 6'd32) begin
            if (trial[32]) begin
              dividend <= dividend << 1;
            end else begin
              dividend <= {trial[31:0], dividend[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            dividend     <= {r_fix, 1'b0, q_fix};
            bus.result_o <= {r_fix, q_fix};
            bus.ready_o  <= DivResultReady;
            cnt          <= '0;
            state        <= DivEnd;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStart) begin
            bus.result_o <= {dividend[64:33], dividend[31:0]};
            bus.ready_o  <= DivResultReady;
          end else begin
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
            state        <= DivFree;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: stimulus queues expected responses, a monitor checks them.
module tb_div;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passed;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: on every rising ready, pop the oldest expectation and compare result and latency.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 && prev !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected ready", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result_o, e.res);
          chk("latency", 64'(cyc), 64'(e.due));
          $display("txn: result=%h ready_cycle=%0d due=%0d", bus.result_o, cyc, e.due);
        end
      end
      prev = bus.ready_o;
    end
  end

  // One request: hold start until ready (bounded), optionally poke annul in DivEnd, then release.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit annul_hold);
    bit seen;
    @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    sb.push_back('{exp, cyc + 1 + lat});
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
      seen = bus.ready_o;
    end
    if (!seen) begin
      chk("ready timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (annul_hold) begin
      bus.annul_i = 1'b1;
      @(negedge clk);
      chk("hold ready under annul", 64'(bus.ready_o), 64'd1);
      chk("hold result under annul", bus.result_o, exp);
      bus.annul_i = 1'b0;
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("release ready", 64'(bus.ready_o), 64'd0);
    chk("release result", bus.result_o, 64'd0);
  endtask

  task automatic expect_silence(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int e0;
    cyc = 0;
    checks = 0;
    passed = 0;
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(bus.ready_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_div(1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33, 1'b1);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    do_div(1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    do_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 1'b0);
    do_div(1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 33, 1'b0);
    do_div(1'b0, 32'h12345678, 32'd0,        64'h0,                  2, 1'b1);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 1'b0);
    do_div(1'b0, 32'd5,        32'd7,        64'h00000005_00000000, 33, 1'b0);

    // Annul mid-iteration: the request is dropped and no result appears.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 20 && cyc < e0 + 9; i++) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    expect_silence("annul in DivOn leaves ready low", 45);

    // Annul together with start in DivFree: never accepted.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    expect_silence("annul with start in DivFree", 40);

    do_div(1'b0, 32'd100, 32'd9, 64'h00000001_0000000B, 33, 1'b0);

    // Asynchronous reset while holding a result in DivEnd clears outputs between edges.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    sb.push_back('{64'h00000001_0000000B, cyc + 34});
    for (int i = 0; i < 60 && bus.ready_o !== 1'b1; i++) @(negedge clk);
    if (bus.ready_o !== 1'b1) begin
      chk("ready timeout before reset", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    #2 rst = 1'b0;
    #1;
    chk("async reset ready", 64'(bus.ready_o), 64'd0);
    chk("async reset result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-DivOn, then a fresh request completes normally.
    @(negedge clk);
    bus.opdata1_i = 32'd7;
    bus.opdata2_i = 32'd2;
    bus.start_i   = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid-iteration reset ready", 64'(bus.ready_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_silence("no result after mid-iteration reset", 40);
    do_div(1'b0, 32'd50, 32'd7, 64'h00000001_00000007, 33, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
